// File: rtl/iob_ram_responder.sv
// -----------------------------------------------------------------------------
// iob_ram_responder
//   IOb native-bus responder backed by an internal word-addressed RAM. Serves
//   one transaction at a time with a programmable number of wait states before
//   the request is accepted and a programmable read latency after acceptance.
//   Writes are byte-strobed and acknowledged by ready_o. Reads are issued by
//   ready_o and return a full word with a one-cycle rvalid_o pulse.
//
// Parameters
//   ADDR_W       byte-address width; RAM depth is 2**(ADDR_W-2) words
//   DATA_W       data width, fixed at 32
//   WAIT_STATES  cycles avalid_i is held before ready_o asserts (0..15)
//   READ_LAT     cycles from the read accept edge to rvalid_o (1..15)
//
// Ports
//   clk_i     clock, all logic on the rising edge
//   rst_n_i   synchronous active-low reset
//   cke_i     clock enable; 0 freezes all state and forces outputs valid=0
//   avalid_i  request valid
//   addr_i    byte address; bits [1:0] are ignored
//   wdata_i   write data
//   wstrb_i   byte enables; all-zero means read
//   rdata_o   read data, valid with rvalid_o, held until the next read returns
//   rvalid_o  read-data valid, single-cycle pulse
//   ready_o   request accepted this cycle
// -----------------------------------------------------------------------------
module iob_ram_responder #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 0,
  parameter int READ_LAT    = 1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                cke_i,
  input  logic                avalid_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                rvalid_o,
  output logic                ready_o
);

  localparam int WSTRB_W = DATA_W / 8;
  localparam int IDX_W   = ADDR_W - 2;
  localparam int DEPTH   = 2 ** IDX_W;

  // Counter reload values; the wait-state reload is only used when WAIT_STATES>0.
  localparam logic [3:0] WS_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [3:0] LAT_INIT = 4'(READ_LAT - 1);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("iob_ram_responder: DATA_W must be 32");
  end
  if (ADDR_W < 3) begin : g_bad_addr_w
    $error("iob_ram_responder: ADDR_W must be at least 3");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
    $error("iob_ram_responder: WAIT_STATES must be in 0..15");
  end
  if (READ_LAT < 1 || READ_LAT > 15) begin : g_bad_lat
    $error("iob_ram_responder: READ_LAT must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_STALL,
    S_RDPEND
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [3:0]          r_lat;
  logic [DATA_W-1:0]   r_pipe;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_ready;
  logic                w_rvalid;
  logic                w_accept;
  logic                w_is_read;
  logic [IDX_W-1:0]    w_idx;
  logic                w_unused_addr;

  assign w_idx         = addr_i[ADDR_W-1:2];
  assign w_unused_addr = ^addr_i[1:0];
  assign w_is_read     = (wstrb_i == '0);

  // Readiness is a function of state only; avalid_i does not feed ready_o.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // w_ready unassigned, which would infer a latch.
    w_ready = 1'b0;
    case (r_state)
      S_IDLE:  w_ready = (WAIT_STATES == 0);
      S_STALL: w_ready = (r_cnt == 4'd0);
      default: w_ready = 1'b0;
    endcase
  end

  assign w_rvalid = (r_state == S_RDPEND) && (r_lat == 4'd0);

  // Both handshake outputs are suppressed while frozen or held in reset, so no
  // transfer can happen in either condition.
  assign ready_o  = w_ready  & cke_i & rst_n_i;
  assign rvalid_o = w_rvalid & cke_i & rst_n_i;
  assign w_accept = avalid_i & ready_o;

  // The freshly read word is forwarded in the rvalid cycle, then the holding
  // register keeps it stable until the next read returns.
  assign rdata_o = rvalid_o ? r_pipe : r_rdata;

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments on all state so every register samples
    // the values from before this edge, independent of statement order.
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_lat   <= 4'd0;
      r_pipe  <= '0;
      r_rdata <= '0;
    end else if (cke_i) begin
      if (rvalid_o) begin
        r_rdata <= r_pipe;
      end
      if (w_accept && w_is_read) begin
        r_pipe <= r_mem[w_idx];
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_read) begin
              r_state <= S_RDPEND;
              r_lat   <= LAT_INIT;
            end
          end else if (avalid_i) begin
            r_state <= S_STALL;
            r_cnt   <= WS_INIT;
          end
        end
        S_STALL: begin
          if (!avalid_i) begin
            // Request withdrawn before acceptance: drop it without effect.
            r_state <= S_IDLE;
          end else if (w_accept) begin
            if (w_is_read) begin
              r_state <= S_RDPEND;
              r_lat   <= LAT_INIT;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RDPEND: begin
          if (r_lat != 4'd0) begin
            r_lat <= r_lat - 4'd1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the RAM array has no reset; clearing it would need a per-word reset
  // path and prevent mapping onto a memory macro. Contents are undefined until
  // written.
  always_ff @(posedge clk_i) begin
    if (w_accept && !w_is_read) begin
      for (int b = 0; b < WSTRB_W; b++) begin
        if (wstrb_i[b]) begin
          r_mem[w_idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_iob_ram_responder.sv
// -----------------------------------------------------------------------------
// tb_iob_ram_responder
//   Three responder instances with different timing parameters share one clock
//   and reset:
//     instance 0: WAIT_STATES=0, READ_LAT=1
//     instance 1: WAIT_STATES=3, READ_LAT=4
//     instance 2: WAIT_STATES=2, READ_LAT=2
//   A per-instance word array models RAM contents; latencies are expected to
//   equal the instance parameters directly.
// -----------------------------------------------------------------------------
module tb_iob_ram_responder;

  localparam int NI = 3;
  localparam int WS_T [NI] = '{0, 3, 2};
  localparam int RL_T [NI] = '{1, 4, 2};

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NI-1:0]         cke;
  logic [NI-1:0]         avalid;
  logic [NI-1:0][11:0]   addr;
  logic [NI-1:0][31:0]   wdata;
  logic [NI-1:0][3:0]    wstrb;
  logic [NI-1:0][31:0]   rdata;
  logic [NI-1:0]         rvalid;
  logic [NI-1:0]         ready;

  logic [31:0] mdl [NI][1024];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    iob_ram_responder #(
      .ADDR_W      (12),
      .DATA_W      (32),
      .WAIT_STATES (WS_T[g]),
      .READ_LAT    (RL_T[g])
    ) u_dut (
      .clk_i    (clk),
      .rst_n_i  (rst_n),
      .cke_i    (cke[g]),
      .avalid_i (avalid[g]),
      .addr_i   (addr[g]),
      .wdata_i  (wdata[g]),
      .wstrb_i  (wstrb[g]),
      .rdata_o  (rdata[g]),
      .rvalid_o (rvalid[g]),
      .ready_o  (ready[g])
    );
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

  // One complete transaction on instance k, starting just after a rising edge.
  // Returns the ready latency (cycles from avalid rising), the read latency
  // (cycles after the accept cycle), the returned word, the number of cycles
  // ready was seen while a read was outstanding, and rvalid pulses seen before
  // acceptance. Latencies are -1 when the bound expires.
  task automatic txn(input int k, input logic [11:0] a, input logic [31:0] d,
                     input logic [3:0] s, output int rdy_lat, output int rv_lat,
                     output logic [31:0] rd, output int busy_rdy, output int early_rv);
    rdy_lat  = -1;
    rv_lat   = -1;
    rd       = '0;
    busy_rdy = 0;
    early_rv = 0;
    avalid[k] = 1'b1;
    addr[k]   = a;
    wdata[k]  = d;
    wstrb[k]  = s;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rvalid[k]) early_rv++;
      if (ready[k]) begin
        rdy_lat = c;
        break;
      end
      tick();
    end
    tick();
    avalid[k] = 1'b0;
    wstrb[k]  = 4'h0;
    if (rdy_lat >= 0 && s != 4'h0) mdl[k][a[11:2]] = merge(mdl[k][a[11:2]], d, s);
    if (rdy_lat >= 0 && s == 4'h0) begin
      for (int c = 1; c < 40; c++) begin
        @(negedge clk);
        if (ready[k]) busy_rdy++;
        if (rvalid[k]) begin
          rv_lat = c;
          rd     = rdata[k];
          break;
        end
        tick();
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    cke    = '1;
    avalid = '0;
    addr   = '0;
    wdata  = '0;
    wstrb  = '0;
    tick();
    tick();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_tests++;
      if (ready[k] !== 1'b0 || rvalid[k] !== 1'b0 || rdata[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: ready=%b rvalid=%b rdata=%h, required 0/0/00000000",
                 k, ready[k], rvalid[k], rdata[k]);
      end
    end
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_tests++;
      if (ready[k] !== (WS_T[k] == 0)) begin
        n_fail++;
        $display("FAIL idle_ready[%0d]: got %b, required %b", k, ready[k], WS_T[k] == 0);
      end
    end
    tick();
  endtask

  task automatic test_write_read();
    int rl, vl, br, er;
    logic [31:0] rd;
    txn(0, 12'h010, 32'hDEADBEEF, 4'hF, rl, vl, rd, br, er);
    n_tests++;
    if (rl !== 0) begin
      n_fail++;
      $display("FAIL t1_write_ready_lat: got %0d, required 0", rl);
    end
    txn(0, 12'h010, 32'h0, 4'h0, rl, vl, rd, br, er);
    n_tests++;
    if (rl !== 0 || vl !== 1) begin
      n_fail++;
      $display("FAIL t1_read_lat: ready %0d rvalid %0d, required 0 and 1", rl, vl);
    end
    n_tests++;
    if (rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL t1_read_data: got %h, required deadbeef", rd);
    end
  endtask

  task automatic test_strobes();
    int rl, vl, br, er;
    logic [31:0] rd;
    txn(0, 12'h020, 32'h11223344, 4'hF, rl, vl, rd, br, er);
    txn(0, 12'h020, 32'h000000AA, 4'h1, rl, vl, rd, br, er);
    txn(0, 12'h023, 32'h0, 4'h0, rl, vl, rd, br, er);
    n_tests++;
    if (rd !== 32'h112233AA) begin
      n_fail++;
      $display("FAIL t2_strobe_low_byte: got %h, required 112233aa", rd);
    end
    txn(0, 12'h022, 32'h00BB0000, 4'h4, rl, vl, rd, br, er);
    txn(0, 12'h021, 32'h0, 4'h0, rl, vl, rd, br, er);
    n_tests++;
    if (rd !== 32'h11BB33AA) begin
      n_fail++;
      $display("FAIL t2_strobe_byte2_alias: got %h, required 11bb33aa", rd);
    end
  endtask

  task automatic test_latency();
    int rl, vl, br, er;
    logic [31:0] rd;
    txn(1, 12'h010, 32'h12345678, 4'hF, rl, vl, rd, br, er);
    n_tests++;
    if (rl !== 3) begin
      n_fail++;
      $display("FAIL t3_write_ready_lat: got %0d, required 3", rl);
    end
    txn(1, 12'h010, 32'h0, 4'h0, rl, vl, rd, br, er);
    n_tests++;
    if (rl !== 3 || vl !== 4) begin
      n_fail++;
      $display("FAIL t3_read_lat: ready %0d rvalid %0d, required 3 and 4", rl, vl);
    end
    n_tests++;
    if (br !== 0 || er !== 0 || rd !== 32'h12345678) begin
      n_fail++;
      $display("FAIL t3_rdpend: ready_during_read=%0d early_rvalid=%0d data=%h, required 0/0/12345678",
               br, er, rd);
    end
  endtask

  task automatic test_reset_mid_read();
    int acc, seen, rl, vl, br, er;
    logic [31:0] rd;
    acc  = -1;
    seen = 0;
    avalid[1] = 1'b1;
    addr[1]   = 12'h010;
    wstrb[1]  = 4'h0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready[1]) begin
        acc = c;
        break;
      end
      tick();
    end
    tick();
    avalid[1] = 1'b0;       // first RDPEND cycle
    tick();
    rst_n = 1'b0;           // second RDPEND cycle
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rvalid[1]) seen++;
      tick();
    end
    n_tests++;
    if (acc !== 3 || seen !== 0) begin
      n_fail++;
      $display("FAIL t4_discard: accept_lat=%0d rvalid_pulses=%0d, required 3 and 0", acc, seen);
    end
    n_tests++;
    if (rdata[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL t4_rdata_cleared: got %h, required 00000000", rdata[1]);
    end
    txn(1, 12'h010, 32'h0, 4'h0, rl, vl, rd, br, er);
    n_tests++;
    if (rl !== 3 || vl !== 4 || rd !== 32'h12345678) begin
      n_fail++;
      $display("FAIL t4_next_read: ready %0d rvalid %0d data %h, required 3/4/12345678", rl, vl, rd);
    end
  endtask

  task automatic test_cke_freeze();
    int bad, lat, rl, vl, br, er;
    logic [31:0] rd;
    bad = 0;
    lat = -1;
    avalid[1] = 1'b1;
    addr[1]   = 12'h040;
    wdata[1]  = 32'hCAFEF00D;
    wstrb[1]  = 4'hF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (ready[1]) bad++;
      tick();
    end
    cke[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ready[1] || rvalid[1]) bad++;
      tick();
    end
    cke[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ready[1]) begin
        lat = c;
        break;
      end
      tick();
    end
    tick();
    avalid[1] = 1'b0;
    wstrb[1]  = 4'h0;
    if (lat >= 0) mdl[1][10'h010] = 32'hCAFEF00D;
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL t5_ready_while_frozen: %0d cycles with ready/rvalid high, required 0", bad);
    end
    n_tests++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL t5_resume_count: ready after %0d cycles, required 1", lat);
    end
    txn(1, 12'h040, 32'h0, 4'h0, rl, vl, rd, br, er);
    n_tests++;
    if (rd !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL t5_write_data: got %h, required cafef00d", rd);
    end
  endtask

  task automatic test_withdraw();
    int bad, rl, vl, br, er;
    logic [31:0] rd;
    bad = 0;
    txn(2, 12'h080, 32'h55AA55AA, 4'hF, rl, vl, rd, br, er);
    n_tests++;
    if (rl !== 2) begin
      n_fail++;
      $display("FAIL t6_write_ready_lat: got %0d, required 2", rl);
    end
    avalid[2] = 1'b1;
    addr[2]   = 12'h080;
    wdata[2]  = 32'hFFFFFFFF;
    wstrb[2]  = 4'hF;
    @(negedge clk);
    if (ready[2]) bad++;
    tick();
    avalid[2] = 1'b0;       // withdrawn while stalled
    wstrb[2]  = 4'h0;
    @(negedge clk);
    if (ready[2]) bad++;
    tick();
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL t6_no_ready_before_withdraw: %0d cycles with ready high, required 0", bad);
    end
    txn(2, 12'h080, 32'h0, 4'h0, rl, vl, rd, br, er);
    n_tests++;
    if (rl !== 2 || rd !== 32'h55AA55AA) begin
      n_fail++;
      $display("FAIL t6_fresh_read: ready %0d data %h, required 2 and 55aa55aa", rl, rd);
    end
  endtask

  task automatic test_back_to_back();
    int bad, rl, vl, br, er;
    logic [31:0] rd;
    logic [31:0] d;
    logic [11:0] a;
    bad = 0;
    avalid[0] = 1'b1;
    wstrb[0]  = 4'hF;
    for (int i = 0; i < 4; i++) begin
      a = 12'h100 + 12'(i * 4);
      d = $urandom;
      addr[0]  = a;
      wdata[0] = d;
      @(negedge clk);
      if (ready[0] !== 1'b1) bad++;
      else mdl[0][a[11:2]] = d;
      tick();
    end
    avalid[0] = 1'b0;
    wstrb[0]  = 4'h0;
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL b2b_ready_held: %0d cycles with ready low, required 0", bad);
    end
    for (int i = 0; i < 4; i++) begin
      a = 12'h100 + 12'(i * 4);
      txn(0, a, 32'h0, 4'h0, rl, vl, rd, br, er);
      n_tests++;
      if (rd !== mdl[0][a[11:2]]) begin
        n_fail++;
        $display("FAIL b2b_readback[%0d]: got %h, required %h", i, rd, mdl[0][a[11:2]]);
      end
    end
  endtask

  task automatic test_random();
    int rl, vl, br, er;
    logic [31:0] rd;
    logic [31:0] d;
    logic [3:0]  s;
    logic [11:0] a;
    logic [9:0]  idx [8];
    for (int k = 0; k < NI; k++) begin
      for (int j = 0; j < 8; j++) begin
        idx[j] = 10'($urandom_range(512, 1023));
        a = {idx[j], 2'b00};
        txn(k, a, $urandom, 4'hF, rl, vl, rd, br, er);
        n_tests++;
        if (rl !== WS_T[k]) begin
          n_fail++;
          $display("FAIL rnd_fill_lat[%0d]: got %0d, required %0d", k, rl, WS_T[k]);
        end
      end
      for (int n = 0; n < 20; n++) begin
        a = {idx[$urandom_range(0, 7)], 2'($urandom)};
        if ($urandom_range(0, 1) == 1) begin
          d = $urandom;
          s = 4'($urandom_range(1, 15));
          txn(k, a, d, s, rl, vl, rd, br, er);
          n_tests++;
          if (rl !== WS_T[k] || er !== 0) begin
            n_fail++;
            $display("FAIL rnd_write[%0d]: ready lat %0d early_rvalid %0d, required %0d and 0",
                     k, rl, er, WS_T[k]);
          end
        end else begin
          txn(k, a, 32'h0, 4'h0, rl, vl, rd, br, er);
          n_tests++;
          if (rl !== WS_T[k] || vl !== RL_T[k] || br !== 0 || er !== 0) begin
            n_fail++;
            $display("FAIL rnd_read_timing[%0d]: ready %0d rvalid %0d busy %0d early %0d, required %0d/%0d/0/0",
                     k, rl, vl, br, er, WS_T[k], RL_T[k]);
          end
          n_tests++;
          if (rd !== mdl[k][a[11:2]]) begin
            n_fail++;
            $display("FAIL rnd_read_data[%0d] @%h: got %h, required %h", k, a, rd, mdl[k][a[11:2]]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobes();
    test_latency();
    test_reset_mid_read();
    test_cke_freeze();
    test_withdraw();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
